// File: rtl/downcount_monitor.sv
// Sequence checker for a down counter: locks on all-ones, flags terminal count,
// counts wraps and mismatches, and latches a fault on repeated consecutive misses.
module downcount_monitor #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned WRAP_W   = 8,
  parameter int unsigned ERR_W    = 4,
  parameter int unsigned MAX_MISS = 3
) (
  input  logic              clk,
  input  logic              rest,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              cnt_vld,
  input  logic              clr,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              locked,
  output logic              fault
);

  localparam int unsigned MISS_W = 4;
  localparam logic [WIDTH-1:0]  CNT_ONES  = '1;
  localparam logic [WRAP_W-1:0] WRAP_ONES = '1;
  localparam logic [ERR_W-1:0]  ERR_ONES  = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [MISS_W-1:0]   miss_run_q, miss_run_d;
  logic [WRAP_W-1:0]   wrap_q, wrap_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                tc_q, tc_d;
  logic                locked_q, locked_d;
  logic                fault_q, fault_d;

  logic [WIDTH-1:0]    exp_val;
  logic                match;
  logic                miss_limit;

  assign exp_val    = WIDTH'(prev_q - WIDTH'(1));
  assign match      = (cnt_in == exp_val);
  assign miss_limit = (MISS_W'(miss_run_q + MISS_W'(1)) == MISS_W'(MAX_MISS));

  // State register
  always_ff @(posedge clk) begin
    if (rest) state_q <= SEARCH;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = SEARCH;
    end else if (cnt_vld) begin
      unique case (state_q)
        SEARCH:  if (cnt_in == CNT_ONES) state_d = TRACK;
        TRACK:   if (!match && miss_limit) state_d = FAULT;
        FAULT:   state_d = FAULT;
        default: state_d = SEARCH;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    prev_d     = prev_q;
    miss_run_d = miss_run_q;
    wrap_d     = wrap_q;
    err_d      = err_q;
    tc_d       = 1'b0;
    if (clr) begin
      miss_run_d = '0;
      wrap_d     = '0;
      err_d      = '0;
    end else if (cnt_vld) begin
      unique case (state_q)
        SEARCH: begin
          if (cnt_in == CNT_ONES) begin
            prev_d     = cnt_in;
            miss_run_d = '0;
          end
        end
        TRACK: begin
          prev_d = cnt_in;
          if (match) begin
            miss_run_d = '0;
            tc_d       = (cnt_in == '0);
            // A matched all-ones after zero is exactly one wrap-around.
            if (prev_q == '0 && wrap_q != WRAP_ONES) wrap_d = WRAP_W'(wrap_q + WRAP_W'(1));
          end else begin
            miss_run_d = MISS_W'(miss_run_q + MISS_W'(1));
            if (err_q != ERR_ONES) err_d = ERR_W'(err_q + ERR_W'(1));
          end
        end
        default: ;
      endcase
    end
    locked_d = (state_d == TRACK);
    fault_d  = (state_d == FAULT);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (rest) begin
      prev_q     <= '0;
      miss_run_q <= '0;
      wrap_q     <= '0;
      err_q      <= '0;
      tc_q       <= 1'b0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      miss_run_q <= miss_run_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      tc_q       <= tc_d;
      locked_q   <= locked_d;
      fault_q    <= fault_d;
    end
  end

  assign tc       = tc_q;
  assign wrap_cnt = wrap_q;
  assign err_cnt  = err_q;
  assign locked   = locked_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_downcount_monitor.sv
// Directed bench for downcount_monitor: a default instance plus a narrow-counter
// instance sharing the same stimulus to exercise saturation.
module tb_downcount_monitor;

  logic       clk;
  logic       rest;
  logic [3:0] cnt_in;
  logic       cnt_vld;
  logic       clr;

  logic       tc, locked, fault;
  logic [7:0] wrap_cnt;
  logic [3:0] err_cnt;

  logic       tc_s, locked_s, fault_s;
  logic [1:0] wrap_cnt_s;
  logic [1:0] err_cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  downcount_monitor dut (
    .clk(clk), .rest(rest), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .clr(clr),
    .tc(tc), .wrap_cnt(wrap_cnt), .err_cnt(err_cnt), .locked(locked), .fault(fault)
  );

  downcount_monitor #(.WIDTH(4), .WRAP_W(2), .ERR_W(2), .MAX_MISS(3)) dut_s (
    .clk(clk), .rest(rest), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .clr(clr),
    .tc(tc_s), .wrap_cnt(wrap_cnt_s), .err_cnt(err_cnt_s), .locked(locked_s), .fault(fault_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one cycle of inputs, then sample just after the edge.
  task automatic step(input logic vld, input logic [3:0] val);
    cnt_vld = vld;
    cnt_in  = val;
    @(posedge clk);
    #1;
    cnt_vld = 1'b0;
    clr     = 1'b0;
    rest    = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1'b0, 4'd0);
  endtask

  initial begin
    logic [3:0] glitch_seq [11];
    logic [3:0] v4;

    rest = 1'b1; clr = 1'b0; cnt_vld = 1'b0; cnt_in = 4'd0;
    @(posedge clk); #1;
    rest = 1'b1;
    step(1'b0, 4'd0);
    check("rst_tc",     32'(tc), 0);
    check("rst_wrap",   32'(wrap_cnt), 0);
    check("rst_err",    32'(err_cnt), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_fault",  32'(fault), 0);

    // Two clean 15..0 sweeps
    for (int r = 0; r < 2; r++) begin
      for (int v = 15; v >= 0; v--) begin
        v4 = 4'(v);
        step(1'b1, v4);
        check("t1_locked", 32'(locked), 1);
        check("t1_tc",     32'(tc), (v == 0) ? 1 : 0);
        check("t1_wrap",   32'(wrap_cnt), (r == 1) ? 1 : 0);
      end
    end
    check("t1_err",   32'(err_cnt), 0);
    check("t1_fault", 32'(fault), 0);

    // Search ignores non-lock values
    do_clr();
    check("t2_clr_locked", 32'(locked), 0);
    check("t2_clr_wrap",   32'(wrap_cnt), 0);
    step(1'b1, 4'd7);  check("t2_locked7", 32'(locked), 0);
    step(1'b1, 4'd6);  check("t2_locked6", 32'(locked), 0);
    step(1'b1, 4'd5);  check("t2_locked5", 32'(locked), 0);
    check("t2_err", 32'(err_cnt), 0);
    check("t2_tc",  32'(tc), 0);
    step(1'b1, 4'd15); check("t2_lock15", 32'(locked), 1);
    step(1'b1, 4'd14); check("t2_lock14", 32'(locked), 1);
    check("t2_err14", 32'(err_cnt), 0);

    // Single jump resyncs
    step(1'b1, 4'd9);  check("t3_err9", 32'(err_cnt), 1);
    step(1'b1, 4'd8);
    step(1'b1, 4'd7);
    check("t3_err",    32'(err_cnt), 1);
    check("t3_locked", 32'(locked), 1);
    check("t3_fault",  32'(fault), 0);

    // Stall drives fault
    do_clr();
    for (int v = 15; v >= 6; v--) begin
      v4 = 4'(v);
      step(1'b1, v4);
    end
    check("t4_err0", 32'(err_cnt), 0);
    step(1'b1, 4'd5); check("t4_err_s1", 32'(err_cnt), 0);
    step(1'b1, 4'd5); check("t4_err_s2", 32'(err_cnt), 1);
    step(1'b1, 4'd5); check("t4_err_s3", 32'(err_cnt), 2);
    check("t4_fault_s3", 32'(fault), 0);
    check("t4_lock_s3",  32'(locked), 1);
    step(1'b1, 4'd5); check("t4_err_s4", 32'(err_cnt), 3);
    check("t4_fault_s4", 32'(fault), 1);
    check("t4_lock_s4",  32'(locked), 0);
    step(1'b1, 4'd4);
    step(1'b1, 4'd15);
    step(1'b1, 4'd0);
    check("t4_err_frozen", 32'(err_cnt), 3);
    check("t4_tc_frozen",  32'(tc), 0);
    check("t4_fault_hold", 32'(fault), 1);
    do_clr();
    check("t4_clr_fault",  32'(fault), 0);
    check("t4_clr_locked", 32'(locked), 0);
    check("t4_clr_err",    32'(err_cnt), 0);
    check("t4_clr_wrap",   32'(wrap_cnt), 0);
    step(1'b1, 4'd15); check("t4_relock", 32'(locked), 1);

    // Wrap saturation: five sweeps give four 0->15 transitions
    do_clr();
    for (int r = 0; r < 5; r++) begin
      for (int v = 15; v >= 0; v--) begin
        v4 = 4'(v);
        step(1'b1, v4);
      end
    end
    check("t5_wrap",   32'(wrap_cnt), 4);
    check("t5_wrap_s", 32'(wrap_cnt_s), 3);
    step(1'b1, 4'd15);
    check("t5_wrap2",   32'(wrap_cnt), 5);
    check("t5_wrap2_s", 32'(wrap_cnt_s), 3);

    // Five isolated glitches
    glitch_seq = '{4'd14, 4'd3, 4'd2, 4'd7, 4'd6, 4'd9, 4'd8, 4'd11, 4'd10, 4'd4, 4'd3};
    for (int i = 0; i < 11; i++) step(1'b1, glitch_seq[i]);
    check("t5_err",     32'(err_cnt), 5);
    check("t5_err_s",   32'(err_cnt_s), 3);
    check("t5_fault",   32'(fault), 0);
    check("t5_fault_s", 32'(fault_s), 0);
    check("t5_locked",  32'(locked), 1);

    // Gaps in valid do not break tracking
    do_clr();
    step(1'b1, 4'd15);
    step(1'b1, 4'd14);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd3);
      check("t6_gap_locked", 32'(locked), 1);
      check("t6_gap_tc",     32'(tc), 0);
    end
    step(1'b1, 4'd13);
    check("t6_err13",    32'(err_cnt), 0);
    check("t6_locked13", 32'(locked), 1);

    // clr wins over a coincident zero sample
    for (int v = 12; v >= 1; v--) begin
      v4 = 4'(v);
      step(1'b1, v4);
    end
    clr = 1'b1;
    step(1'b1, 4'd0);
    check("t6_clr_tc",     32'(tc), 0);
    check("t6_clr_locked", 32'(locked), 0);
    step(1'b1, 4'd14);
    check("t6_search_locked", 32'(locked), 0);
    check("t6_search_err",    32'(err_cnt), 0);

    // Reset mid-track
    step(1'b1, 4'd15);
    step(1'b1, 4'd14);
    step(1'b1, 4'd9);
    check("t7_pre_err",    32'(err_cnt), 1);
    check("t7_pre_locked", 32'(locked), 1);
    rest = 1'b1;
    step(1'b1, 4'd8);
    check("t7_tc",     32'(tc), 0);
    check("t7_wrap",   32'(wrap_cnt), 0);
    check("t7_err",    32'(err_cnt), 0);
    check("t7_locked", 32'(locked), 0);
    check("t7_fault",  32'(fault), 0);
    step(1'b1, 4'd7);
    check("t7_after_locked", 32'(locked), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
